// File: rtl/reg_file_wb.sv
// reg_file_wb: 8x8 register file with a one-entry write-back buffer and read bypass
module reg_file_wb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int ADDR  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WRITEENABLE,
    input  logic [ADDR-1:0]  WRITEREG,
    input  logic [WIDTH-1:0] IN,
    input  logic [ADDR-1:0]  READREG1,
    input  logic [ADDR-1:0]  READREG2,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2
);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             pend_valid_q, pend_valid_d;
    logic [ADDR-1:0]  pend_addr_q, pend_addr_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;

    // Next state: commit the buffered write to the array while capturing the new one
    always_comb begin
        regs_d = regs_q;
        if (pend_valid_q) regs_d[pend_addr_q] = pend_data_q;
        pend_valid_d = WRITEENABLE;
        pend_addr_d  = WRITEENABLE ? WRITEREG : pend_addr_q;
        pend_data_d  = WRITEENABLE ? IN : pend_data_q;
    end

    // State registers; reset clears everything and drops any pending write
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            regs_q       <= regs_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    // Read ports: the buffered value wins over the array copy of the same register
    always_comb begin
        OUT1 = (pend_valid_q && pend_addr_q == READREG1) ? pend_data_q : regs_q[READREG1];
        OUT2 = (pend_valid_q && pend_addr_q == READREG2) ? pend_data_q : regs_q[READREG2];
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: table-driven and randomized checks of reg_file_wb against an architectural model
module tb_reg_file_wb;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       WRITEENABLE = 1'b0;
    logic [2:0] WRITEREG = '0;
    logic [7:0] IN = '0;
    logic [2:0] READREG1 = '0;
    logic [2:0] READREG2 = '0;
    logic [7:0] OUT1, OUT2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit       clk_edge;
        bit       rst_n;
        bit       we;
        bit [2:0] wreg;
        bit [7:0] din;
        bit [2:0] r1;
        bit [2:0] r2;
        bit [7:0] exp1;
        bit [7:0] exp2;
        string    name;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model [8];

    reg_file_wb dut (
        .CLK(CLK), .RESET(RESET), .WRITEENABLE(WRITEENABLE), .WRITEREG(WRITEREG),
        .IN(IN), .READREG1(READREG1), .READREG2(READREG2), .OUT1(OUT1), .OUT2(OUT2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input bit e, input bit rn, input bit we, input bit [2:0] wr,
                                input bit [7:0] d, input bit [2:0] a1, input bit [2:0] a2,
                                input bit [7:0] x1, input bit [7:0] x2, input string n);
        vec_t v;
        v.clk_edge = e; v.rst_n = rn; v.we = we; v.wreg = wr; v.din = d;
        v.r1 = a1; v.r2 = a2; v.exp1 = x1; v.exp2 = x2; v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        add(1, 0, 0, 0, 8'h00, 3, 7, 8'h00, 8'h00, "reset_init");
        add(1, 1, 1, 3, 8'h55, 3, 7, 8'h55, 8'h00, "write_r3");
        add(1, 0, 1, 3, 8'h77, 3, 7, 8'h00, 8'h00, "reset_clears");
        add(1, 1, 0, 0, 8'h00, 3, 3, 8'h00, 8'h00, "write_in_reset_dropped");
        add(1, 1, 1, 2, 8'd25, 2, 2, 8'd25, 8'd25, "write_r2_bypass");
        add(1, 1, 0, 0, 8'h00, 2, 2, 8'd25, 8'd25, "write_r2_committed");
        add(1, 1, 1, 4, 8'd34, 4, 2, 8'd34, 8'd25, "r4_first");
        add(1, 1, 1, 4, 8'd1,  4, 2, 8'd1,  8'd25, "r4_second_bypass");
        add(1, 1, 0, 0, 8'h00, 4, 4, 8'd1,  8'd1,  "r4_newer_kept");
        for (int i = 0; i < 8; i++)
            add(1, 1, 1, 3'(i), 8'(i + 1), 3'(i), 3'(i), 8'(i + 1), 8'(i + 1), "seq_write");
        add(1, 1, 0, 0, 8'h00, 7, 0, 8'h08, 8'h01, "seq_idle");
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 0, 8'h00, 3'(i), 3'(7 - i), 8'(i + 1), 8'(8 - i), "sweep");
        add(1, 1, 1, 5, 8'hAA, 5, 5, 8'hAA, 8'hAA, "dual_pending");
        add(1, 1, 0, 0, 8'h00, 5, 5, 8'hAA, 8'hAA, "dual_committed");
        add(1, 1, 1, 6, 8'h0F, 6, 5, 8'h0F, 8'hAA, "pend_r6");
        add(1, 0, 0, 0, 8'h00, 6, 5, 8'h00, 8'h00, "reset_discards_pending");
        add(1, 1, 0, 0, 8'h00, 6, 6, 8'h00, 8'h00, "pending_stays_gone");

        foreach (vecs[k]) begin
            RESET = vecs[k].rst_n; WRITEENABLE = vecs[k].we; WRITEREG = vecs[k].wreg;
            IN = vecs[k].din; READREG1 = vecs[k].r1; READREG2 = vecs[k].r2;
            if (vecs[k].clk_edge) @(posedge CLK);
            #1;
            chk({vecs[k].name, "_out1"}, OUT1, vecs[k].exp1);
            chk({vecs[k].name, "_out2"}, OUT2, vecs[k].exp2);
        end

        // Random phase: the model holds the architectural register values, updated on the write edge
        RESET = 1'b0; WRITEENABLE = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            RESET = ($urandom_range(0, 19) != 0);
            WRITEENABLE = $urandom_range(0, 1) == 1;
            WRITEREG = 3'($urandom_range(0, 7));
            IN = 8'($urandom);
            READREG1 = 3'($urandom_range(0, 7));
            READREG2 = 3'($urandom_range(0, 7));
            @(posedge CLK);
            if (!RESET) for (int i = 0; i < 8; i++) model[i] = 8'h00;
            else if (WRITEENABLE) model[WRITEREG] = IN;
            #1;
            IN = 8'($urandom);
            chk("rand_out1", OUT1, model[READREG1]);
            chk("rand_out2", OUT2, model[READREG2]);
            READREG1 = 3'($urandom_range(0, 7));
            READREG2 = 3'($urandom_range(0, 7));
            #1;
            chk("rand_comb_out1", OUT1, model[READREG1]);
            chk("rand_comb_out2", OUT2, model[READREG2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
